pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 172 +++++++++++++++++
 tb/tb_pc_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch program-counter generator: IDLE/RUN/HALT sequencing, stall, pending branch, trap redirect.
// Define PC_GEN_RAS_EN to compile in the circular return-address stack (call_i/ret_i).
//   state | meaning
//   IDLE  | after reset, waiting for start_i; pc_o not a valid fetch address
//   RUN   | fetching; pc_o advances or redirects when allowed
//   HALT  | fetching stopped; only rst_i leaves this state
module pc_gen #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 'h80,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_write_i,
  input  logic             halt_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             trap_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
  output logic             misalign_o,
  output logic             ras_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_v_q, pend_v_d;
  logic [WIDTH-1:0] pend_t_q, pend_t_d;
  logic             misalign_q, misalign_d;
  logic             ras_err_q, ras_err_d;
  logic             ras_push, ras_pop;
  logic             ras_empty;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + STEP_W;

  function automatic logic misaligned(input logic [WIDTH-1:0] t);
    return (t % STEP_W) != '0;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VEC;
      pend_v_q   <= 1'b0;
      pend_t_q   <= '0;
      misalign_q <= 1'b0;
      ras_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_t_q   <= pend_t_d;
      misalign_q <= misalign_d;
      ras_err_q  <= ras_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_t_d   = pend_t_q;
    misalign_d = 1'b0;
    ras_err_d  = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_i) state_d = S_HALT;
        // Trap ignores the stall and still lands when halting in the same cycle.
        if (trap_i) begin
          pc_d       = TRAP_VEC;
          pend_v_d   = 1'b0;
          misalign_d = misaligned(TRAP_VEC);
        end else if (!halt_i) begin
          if (pc_write_i) begin
            ras_push = RAS_EN && call_i;
            if (branch_i) begin
              pc_d       = branch_target_i;
              pend_v_d   = 1'b0;
              misalign_d = misaligned(branch_target_i);
            end else if (pend_v_q) begin
              pc_d       = pend_t_q;
              pend_v_d   = 1'b0;
              misalign_d = misaligned(pend_t_q);
            end else if (RAS_EN && ret_i && !ras_empty) begin
              ras_pop    = 1'b1;
              pc_d       = ras_top;
              misalign_d = misaligned(ras_top);
            end else begin
              pc_d      = pc_inc;
              ras_err_d = RAS_EN && ret_i;
            end
          end else if (branch_i) begin
            pend_v_d = 1'b1;
            pend_t_d = branch_target_i;
          end
        end
      end
      default: begin
      end
    endcase
  end

`ifdef PC_GEN_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_wp_q;
  logic [PW:0]      ras_cnt_q;
  logic [PW-1:0]    ras_top_idx;

  assign ras_top_idx = ras_wp_q - PW'(1);
  assign ras_top     = ras_mem[ras_top_idx];
  assign ras_empty   = (ras_cnt_q == '0);

  // Full stack wraps the write pointer, overwriting the oldest entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ras_wp_q  <= '0;
      ras_cnt_q <= '0;
    end else if (ras_pop && !ras_push) begin
      ras_wp_q  <= ras_top_idx;
      ras_cnt_q <= ras_cnt_q - (PW + 1)'(1);
    end else if (ras_push && !ras_pop) begin
      ras_wp_q <= ras_wp_q + PW'(1);
      if (ras_cnt_q != (PW + 1)'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + (PW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && ras_push) begin
      if (ras_pop) ras_mem[ras_top_idx] <= pc_inc;
      else         ras_mem[ras_wp_q]    <= pc_inc;
    end
  end

  assign ras_err_o = ras_err_q;
`else
  logic unused_ras;

  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign unused_ras = ^{ras_push, ras_pop, ras_err_q, call_i, ret_i};
  assign ras_err_o  = 1'b0;
`endif

  assign pc_o       = pc_q;
  assign pc_valid_o = (state_q == S_RUN);
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a 32-bit and an 8-bit instance share stimulus and are
// compared each cycle against a queue-based reference model, plus directed spot checks.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, we, halt, br, trap, call, ret;
  logic [31:0] bt;

  logic [31:0] pc32;
  logic        v32, mis32, err32;
  logic [7:0]  pc8;
  logic        v8, mis8, err8;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state, index 0 = 32-bit instance, 1 = 8-bit instance
  logic [31:0] m_pc [2];
  logic        m_run [2];
  logic        m_halted [2];
  logic        m_pv [2];
  logic [31:0] m_pt [2];
  logic        m_mis [2];
  logic        m_err [2];
  logic [31:0] m_q0 [$];
  logic [31:0] m_q1 [$];

  always #5 clk = ~clk;

  pc_gen #(.WIDTH(32), .RAS_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_write_i(we), .halt_i(halt),
    .branch_i(br), .branch_target_i(bt), .trap_i(trap), .call_i(call), .ret_i(ret),
    .pc_o(pc32), .pc_valid_o(v32), .misalign_o(mis32), .ras_err_o(err32)
  );

  pc_gen #(.WIDTH(8), .RAS_DEPTH(2)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_write_i(we), .halt_i(halt),
    .branch_i(br), .branch_target_i(bt[7:0]), .trap_i(trap), .call_i(call), .ret_i(ret),
    .pc_o(pc8), .pc_valid_o(v8), .misalign_o(mis8), .ras_err_o(err8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] mask;
      logic [31:0] old;
      logic [31:0] q [$];
      mask = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      if (k == 0) q = m_q0; else q = m_q1;
      old = m_pc[k];
      m_mis[k] = 1'b0;
      m_err[k] = 1'b0;
      if (rst) begin
        m_pc[k] = 32'h0; m_run[k] = 1'b0; m_halted[k] = 1'b0; m_pv[k] = 1'b0;
        q.delete();
      end else if (!m_run[k] && !m_halted[k]) begin
        if (start) m_run[k] = 1'b1;
      end else if (m_run[k]) begin
        if (trap) begin
          m_pc[k] = 32'h80;
          m_pv[k] = 1'b0;
        end else if (!halt) begin
          if (we) begin
            if (br) begin
              m_pc[k] = bt & mask; m_pv[k] = 1'b0; m_mis[k] = (bt % 4) != 0;
            end else if (m_pv[k]) begin
              m_pc[k] = m_pt[k]; m_pv[k] = 1'b0; m_mis[k] = (m_pt[k] % 4) != 0;
            end else if (RAS && ret && q.size() > 0) begin
              m_pc[k] = q.pop_back(); m_mis[k] = (m_pc[k] % 4) != 0;
            end else begin
              m_pc[k] = (old + 4) & mask; m_err[k] = RAS && ret;
            end
            if (RAS && call) begin
              q.push_back((old + 4) & mask);
              if (q.size() > 2) void'(q.pop_front());
            end
          end else if (br) begin
            m_pv[k] = 1'b1; m_pt[k] = bt & mask;
          end
        end
        if (halt) begin m_run[k] = 1'b0; m_halted[k] = 1'b1; end
      end
      if (k == 0) m_q0 = q; else m_q1 = q;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("pc32", pc32, m_pc[0]);
    chk("valid32", v32, m_run[0]);
    chk("misalign32", mis32, m_mis[0]);
    chk("ras_err32", err32, m_err[0]);
    chk("pc8", {24'h0, pc8}, m_pc[1]);
    chk("valid8", v8, m_run[1]);
    chk("misalign8", mis8, m_mis[1]);
    chk("ras_err8", err8, m_err[1]);
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; we = 0; halt = 0; br = 0; trap = 0; call = 0; ret = 0; bt = 32'h0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_run[k] = 0; m_halted[k] = 0; m_pv[k] = 0; m_pt[k] = 0;
      m_mis[k] = 0; m_err[k] = 0;
    end
    idle_inputs();

    // reset overrides a simultaneous start
    rst = 1; start = 1; br = 1; bt = 32'h44;
    step();
    chk("rst_pc", pc32, 32'h0);
    chk("rst_valid", v32, 1'b0);

    // start pulse then free increments: 0,0,4,8,12
    rst = 0; br = 0; start = 1;
    step();
    chk("start_pc", pc32, 32'h0);
    chk("start_valid", v32, 1'b1);
    start = 0; we = 1;
    step(); chk("inc1", pc32, 32'h4);
    step(); chk("inc2", pc32, 32'h8);
    step(); chk("inc3", pc32, 32'hC);

    // stalled branch becomes pending, applied once the stall releases
    we = 0; br = 1; bt = 32'h200;
    step(); chk("stall1", pc32, 32'hC);
    br = 0;
    step(); step(); chk("stall3", pc32, 32'hC);
    we = 1;
    step(); chk("pend_apply", pc32, 32'h200);

    // trap while stalled discards the pending branch
    we = 0; br = 1; bt = 32'h300;
    step();
    br = 0; trap = 1;
    step(); chk("trap_pc", pc32, 32'h80);
    trap = 0; we = 1;
    step(); chk("after_trap", pc32, 32'h84);

    // 8-bit wrap and misaligned branch pulse
    br = 1; bt = 32'hFC;
    step(); chk("w8_fc", {24'h0, pc8}, 32'hFC);
    br = 0;
    step(); chk("w8_wrap", {24'h0, pc8}, 32'h0);
    br = 1; bt = 32'h03;
    step(); chk("mis_pulse", mis8, 1'b1);
    br = 0;
    step(); chk("mis_clear", mis8, 1'b0);

`ifdef PC_GEN_RAS_EN
    br = 1; bt = 32'h10;
    step();
    call = 1; bt = 32'h20; step();
    bt = 32'h30; step();
    bt = 32'h50; step();
    br = 0; call = 0; ret = 1;
    step(); chk("ret1", pc32, 32'h34);
    step(); chk("ret2", pc32, 32'h24);
    step(); chk("ret_err", err32, 1'b1); chk("ret_err_pc", pc32, 32'h28);
    ret = 0;
    step(); chk("ret_err_clr", err32, 1'b0);
`endif

    // constrained-random traffic against the model
    idle_inputs();
    rst = 1;
    step();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 99) < 30);
      we    = ($urandom_range(0, 99) < 75);
      halt  = ($urandom_range(0, 99) < 2);
      br    = ($urandom_range(0, 99) < 20);
      trap  = ($urandom_range(0, 99) < 4);
      call  = ($urandom_range(0, 99) < 15);
      ret   = ($urandom_range(0, 99) < 15);
      bt    = $urandom;
      if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
      step();
    end

    // reset out of HALT clears the pending branch
    idle_inputs();
    rst = 1; step();
    rst = 0; start = 1; step();
    start = 0; br = 1; bt = 32'h444; step();
    br = 0; halt = 1; step();
    chk("halt_valid", v32, 1'b0);
    halt = 0; we = 1; step();
    chk("halt_frozen", pc32, 32'h0);
    rst = 1; step();
    chk("halt_rst_pc", pc32, 32'h0);
    rst = 0; start = 1; step();
    start = 0; step();
    chk("no_stale_pend", pc32, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
